// File: rtl/sad_pe_array.sv
// sad_pe_array: LANES-wide |cur-ref| row reduction accumulated over ROWS beats.
// Optional best-candidate tracker enabled by defining SAD_MIN_TRACK_EN.
module sad_pe_array #(
    parameter int PIX_W = 8,
    parameter int LANES = 16,
    parameter int ROWS  = 16,
    parameter int IDX_W = 8,
    localparam int SAD_W = PIX_W + $clog2(LANES) + $clog2(ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   roll,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*PIX_W-1:0] cur,
    input  logic [LANES*PIX_W-1:0] ref_pix,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SAD_W-1:0]       sad,
    output logic [IDX_W-1:0]       cand_idx
`ifdef SAD_MIN_TRACK_EN
    ,
    input  logic                   clr_min,
    output logic [SAD_W-1:0]       min_sad,
    output logic [IDX_W-1:0]       min_idx
`endif
);

    localparam int LOG_L = $clog2(LANES);
    localparam int LOG_R = $clog2(ROWS);
    localparam int SUM_W = PIX_W + LOG_L;
    localparam int CNT_W = LOG_R;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_ACCUM,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t                        state_q, state_d;
    logic                          drain_q, drain_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          v1_q, v1_d;
    logic [LANES-1:0][PIX_W-1:0]   d1_q, d1_d;
    logic                          v2_q, v2_d;
    logic [SUM_W-1:0]              sum_q, sum_d;
    logic [SAD_W-1:0]              acc_q, acc_d;
    logic [IDX_W-1:0]              idx_q, idx_d;

    logic                          accept;
    logic                          flush;
    logic                          hs;

    function automatic logic [PIX_W-1:0] abs_diff(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b
    );
        return (a > b) ? (a - b) : (b - a);
    endfunction

    assign accept    = in_valid & in_ready;
    assign sad       = acc_q;
    assign cand_idx  = idx_q;

    // Control FSM: accumulate beats, flush the pipe, then hold the result.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        flush     = 1'b0;
        hs        = 1'b0;
        unique case (state_q)
            S_ACCUM: begin
                in_ready = ~roll;
                flush    = roll;
                if (!roll && in_valid && cnt_q == LAST_ROW) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (roll) begin
                    flush   = 1'b1;
                    state_d = S_ACCUM;
                end else if (drain_q) begin
                    state_d = S_HOLD;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                hs        = out_ready;
                if (out_ready) begin
                    state_d = S_ACCUM;
                end
            end
            default: begin
                state_d = S_ACCUM;
            end
        endcase
    end

    // S1: per-lane absolute difference, captured only on an accepted beat.
    always_comb begin
        d1_d = d1_q;
        v1_d = accept;
        if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                d1_d[i] = abs_diff(cur[i*PIX_W +: PIX_W],
                                   ref_pix[i*PIX_W +: PIX_W]);
            end
        end
    end

    // S2: full-width reduction of the lane differences into one row sum.
    always_comb begin
        sum_d = sum_q;
        v2_d  = v1_q & ~flush;
        if (v1_q) begin
            sum_d = '0;
            for (int i = 0; i < LANES; i++) begin
                sum_d = sum_d + SUM_W'(d1_q[i]);
            end
        end
    end

    // S3 and bookkeeping: block accumulator, row counter, candidate index.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (flush || hs) begin
            acc_d = '0;
        end else if (v2_q) begin
            acc_d = acc_q + SAD_W'(sum_q);
        end
        if (flush || hs) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = (cnt_q == LAST_ROW) ? '0 : cnt_q + CNT_W'(1);
        end
        if (hs) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ACCUM;
            drain_q <= 1'b0;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            d1_q    <= '0;
            v2_q    <= 1'b0;
            sum_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
            v1_q    <= v1_d;
            d1_q    <= d1_d;
            v2_q    <= v2_d;
            sum_q   <= sum_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

`ifdef SAD_MIN_TRACK_EN
    logic [SAD_W-1:0] min_sad_q, min_sad_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;

    assign min_sad = min_sad_q;
    assign min_idx = min_idx_q;

    // Best-so-far tracker; a clear in a handshake cycle loads that result.
    always_comb begin
        min_sad_d = min_sad_q;
        min_idx_d = min_idx_q;
        if (clr_min) begin
            min_sad_d = '1;
            min_idx_d = '0;
        end
        if (hs && (clr_min || acc_q < min_sad_q)) begin
            min_sad_d = acc_q;
            min_idx_d = idx_q;
        end
    end

    // Tracker registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_sad_q <= '1;
            min_idx_q <= '0;
        end else begin
            min_sad_q <= min_sad_d;
            min_idx_q <= min_idx_d;
        end
    end
`endif

endmodule
